// File: rtl/osd_pkg.sv
// Shared constants, state type and ASCII translation for the OSD text writer.
package osd_pkg;

  localparam int OSD_COLS  = 16;
  localparam int OSD_ROWS  = 8;
  localparam int OSD_CELLS = OSD_COLS * OSD_ROWS;
  localparam int ADDR_W    = 7;
  localparam int CODE_W    = 6;

  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_NL      = 8'h03;
  localparam logic [7:0] CMD_ON      = 8'h04;
  localparam logic [7:0] CMD_OFF     = 8'h05;
  localparam logic [7:0] CMD_CLR_OVF = 8'h06;
  localparam logic [7:0] ASCII_CR    = 8'h0D;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    CLEAR
  } osd_wr_state_t;

  // Lowercase folds onto uppercase; anything outside 0x20-0x7F is bad.
  function automatic logic [CODE_W-1:0] ascii_to_code(
    input logic [7:0]        c,
    input logic [CODE_W-1:0] bad
  );
    logic [7:0] t;
    t = {2'b00, bad};
    if (c >= 8'h20 && c <= 8'h5F) begin
      t = c - 8'h20;
    end else if (c >= 8'h60 && c <= 8'h7F) begin
      t = c - 8'h40;
    end
    return t[CODE_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] next_row(
    input logic [ADDR_W-1:0] cur
  );
    logic [2:0] row;
    row = cur[6:4] + 3'd1;
    return {row, 4'd0};
  endfunction

endpackage

// File: rtl/osd_cmd_fifo.sv
// Host command FIFO: registered full/empty, push accepted on a
// full FIFO when a pop happens in the same cycle.
module osd_cmd_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             wr_en, rd_en;

  always_comb begin
    rd_en    = pop & ~empty_q;
    wr_en    = push & (~full_q | rd_en);
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
    count_d  = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    full_d   = (count_d == (AW+1)'(DEPTH));
    empty_d  = (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = empty_q;
  assign full  = full_q;

endmodule

// File: rtl/osd_text_writer.sv
// Host byte writes to OSD cell writes: ASCII translation, text cursor
// and a 128-cycle screen clear.
module osd_text_writer
  import osd_pkg::*;
#(
  parameter int                FIFO_DEPTH = 4,
  parameter logic [CODE_W-1:0] SPACE_CODE = 6'd0,
  parameter logic [CODE_W-1:0] BAD_CODE   = 6'd31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_wr,
  input  logic              host_addr,
  input  logic [7:0]        host_din,
  output logic              host_full,
  output logic              ovf,
  output logic [CODE_W-1:0] char_data,
  output logic              char_we,
  output logic [ADDR_W-1:0] char_addr,
  output logic [ADDR_W-1:0] cursor,
  output logic              osd_en,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(OSD_CELLS - 1);

  osd_wr_state_t     st_q, st_d;
  logic [8:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] cursor_q, cursor_d;
  logic              osd_en_q, osd_en_d;
  logic              ovf_q, ovf_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CODE_W-1:0] data_q, data_d;

  logic [8:0] fifo_dout;
  logic       fifo_empty;
  logic       fifo_full;
  logic       pop;
  logic       drop;
  logic       ovf_clr;

  osd_cmd_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (host_wr),
    .din   ({host_addr, host_din}),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Cell writes are registered one state early so that char_we
  // lines up with the EXEC cycle and with each CLEAR counter value.
  always_comb begin
    st_d     = st_q;
    cmd_d    = cmd_q;
    cnt_d    = cnt_q;
    cursor_d = cursor_q;
    osd_en_d = osd_en_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    pop      = 1'b0;
    ovf_clr  = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop   = 1'b1;
          cmd_d = fifo_dout;
          st_d  = EXEC;
          if (!fifo_dout[8] && fifo_dout[7:0] != ASCII_CR) begin
            we_d   = 1'b1;
            addr_d = cursor_q;
            data_d = ascii_to_code(fifo_dout[7:0], BAD_CODE);
          end
        end
      end
      EXEC: begin
        st_d = IDLE;
        if (!cmd_q[8]) begin
          if (cmd_q[7:0] == ASCII_CR) begin
            cursor_d = next_row(cursor_q);
          end else begin
            cursor_d = cursor_q + 7'd1;
          end
        end else if (cmd_q[7]) begin
          cursor_d = cmd_q[6:0];
        end else begin
          case (cmd_q[7:0])
            CMD_CLEAR: begin
              st_d   = CLEAR;
              cnt_d  = '0;
              we_d   = 1'b1;
              addr_d = '0;
              data_d = SPACE_CODE;
            end
            CMD_HOME:    cursor_d = '0;
            CMD_NL:      cursor_d = next_row(cursor_q);
            CMD_ON:      osd_en_d = 1'b1;
            CMD_OFF:     osd_en_d = 1'b0;
            CMD_CLR_OVF: ovf_clr  = 1'b1;
            default:     ;
          endcase
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_CELL) begin
          st_d     = IDLE;
          cursor_d = '0;
        end else begin
          cnt_d  = cnt_q + 7'd1;
          we_d   = 1'b1;
          addr_d = cnt_q + 7'd1;
          data_d = SPACE_CODE;
        end
      end
      default: st_d = IDLE;
    endcase
    drop  = host_wr & fifo_full & ~pop;
    ovf_d = (ovf_q & ~ovf_clr) | drop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= IDLE;
      cmd_q    <= '0;
      cnt_q    <= '0;
      cursor_q <= '0;
      osd_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      st_q     <= st_d;
      cmd_q    <= cmd_d;
      cnt_q    <= cnt_d;
      cursor_q <= cursor_d;
      osd_en_q <= osd_en_d;
      ovf_q    <= ovf_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign host_full = fifo_full;
  assign ovf       = ovf_q;
  assign char_we   = we_q;
  assign char_addr = addr_q;
  assign char_data = data_q;
  assign cursor    = cursor_q;
  assign osd_en    = osd_en_q;
  assign busy      = (st_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_osd_text_writer.sv
// Scoreboard bench: a host-side model queues expected cell writes,
// a negedge monitor retires them as char_we pulses appear.
module tb_osd_text_writer;

  logic       clk;
  logic       rst;
  logic       host_wr;
  logic       host_addr;
  logic [7:0] host_din;
  logic       host_full;
  logic       ovf;
  logic [5:0] char_data;
  logic       char_we;
  logic [6:0] char_addr;
  logic [6:0] cursor;
  logic       osd_en;
  logic       busy;

  int n_chk;
  int n_err;
  int n_we;

  logic [12:0] exp_q[$];
  logic [6:0]  m_cur;
  logic        m_en;

  osd_text_writer dut (
    .clk       (clk),
    .rst       (rst),
    .host_wr   (host_wr),
    .host_addr (host_addr),
    .host_din  (host_din),
    .host_full (host_full),
    .ovf       (ovf),
    .char_data (char_data),
    .char_we   (char_we),
    .char_addr (char_addr),
    .cursor    (cursor),
    .osd_en    (osd_en),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] exp_code(input logic [7:0] b);
    logic [7:0] t;
    if (b < 8'h20 || b > 8'h7F) t = 8'd31;
    else if (b >= 8'h60) t = b - 8'd64;
    else t = b - 8'd32;
    return t[5:0];
  endfunction

  task automatic model(input logic a, input logic [7:0] d);
    if (!a) begin
      if (d == 8'h0D) begin
        m_cur = {m_cur[6:4] + 3'd1, 4'd0};
      end else begin
        exp_q.push_back({m_cur, exp_code(d)});
        m_cur = m_cur + 7'd1;
      end
    end else if (d[7]) begin
      m_cur = d[6:0];
    end else begin
      case (d)
        8'h01: begin
          for (int i = 0; i < 128; i++) exp_q.push_back({7'(i), 6'd0});
          m_cur = 7'd0;
        end
        8'h02: m_cur = 7'd0;
        8'h03: m_cur = {m_cur[6:4] + 3'd1, 4'd0};
        8'h04: m_en = 1'b1;
        8'h05: m_en = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic send(input logic a, input logic [7:0] d);
    model(a, d);
    host_addr = a;
    host_din  = d;
    host_wr   = 1'b1;
    @(posedge clk); #1;
    host_wr = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 600 && (busy || exp_q.size() != 0); k++) begin
      @(posedge clk); #1;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_cursor"}, 32'(cursor), 32'(m_cur));
    check({tag, "_osd_en"}, 32'(osd_en), 32'(m_en));
  endtask

  always @(negedge clk) begin
    if (char_we) begin
      n_we++;
      if (exp_q.size() == 0) begin
        check("we_unexpected", 32'(char_we), 32'd0);
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        check("we_addr", 32'(char_addr), 32'(e[12:6]));
        check("we_data", 32'(char_data), 32'(e[5:0]));
        check("we_busy", 32'(busy), 32'd1);
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_we"}, 32'(char_we), 32'd0);
    check({tag, "_addr"}, 32'(char_addr), 32'd0);
    check({tag, "_data"}, 32'(char_data), 32'd0);
    check({tag, "_cursor"}, 32'(cursor), 32'd0);
    check({tag, "_osd_en"}, 32'(osd_en), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_full"}, 32'(host_full), 32'd0);
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
  endtask

  initial begin
    int base;
    n_chk = 0;
    n_err = 0;
    n_we = 0;
    m_cur = 7'd0;
    m_en = 1'b0;
    rst = 1'b1;
    host_wr = 1'b0;
    host_addr = 1'b0;
    host_din = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // 'A': write visible two cycles after the strobe cycle
    send(1'b0, 8'h41);
    check("lat_n1_we", 32'(char_we), 32'd0);
    @(posedge clk); #1;
    check("lat_n2_we", 32'(char_we), 32'd1);
    check("lat_n2_addr", 32'(char_addr), 32'd0);
    check("lat_n2_data", 32'(char_data), 32'd33);
    @(posedge clk); #1;
    check("hold_we", 32'(char_we), 32'd0);
    check("hold_addr", 32'(char_addr), 32'd0);
    check("hold_data", 32'(char_data), 32'd33);
    wait_idle("a");

    send(1'b1, 8'h8F);
    send(1'b0, 8'h61);
    send(1'b0, 8'h42);
    wait_idle("ab");
    check("ab_cursor17", 32'(cursor), 32'd17);

    send(1'b1, 8'h81);
    send(1'b0, 8'h0D);
    send(1'b0, 8'h5A);
    wait_idle("nl_z");

    send(1'b1, 8'hFF);
    send(1'b0, 8'h58);
    wait_idle("wrap");
    check("wrap_cursor0", 32'(cursor), 32'd0);

    send(1'b0, 8'h7E);
    send(1'b0, 8'h05);
    send(1'b0, 8'h9A);
    wait_idle("bad");

    send(1'b1, 8'h04);
    wait_idle("on");
    send(1'b1, 8'h05);
    wait_idle("off");

    send(1'b1, 8'h85);
    send(1'b1, 8'h02);
    wait_idle("home");
    send(1'b1, 8'h8A);
    send(1'b1, 8'h03);
    wait_idle("ctl_nl");
    send(1'b1, 8'hF3);
    send(1'b1, 8'h03);
    wait_idle("ctl_nl_wrap");
    send(1'b1, 8'h3C);
    wait_idle("nop");

    // Overflow during a clear
    send(1'b1, 8'h01);
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) model(1'b0, 8'h48 + 8'(i));
      host_addr = 1'b0;
      host_din  = 8'h48 + 8'(i);
      host_wr   = 1'b1;
      @(posedge clk); #1;
      check("burst_full", 32'(host_full), 32'(i >= 3));
      check("burst_ovf", 32'(ovf), 32'(i >= 4));
      check("burst_busy", 32'(busy), 32'd1);
    end
    host_wr = 1'b0;
    wait_idle("burst");
    check("burst_full_end", 32'(host_full), 32'd0);
    check("burst_ovf_end", 32'(ovf), 32'd1);
    send(1'b1, 8'h06);
    wait_idle("clr_ovf");
    check("clr_ovf", 32'(ovf), 32'd0);

    // Reset in the middle of a clear
    send(1'b1, 8'h04);
    wait_idle("on2");
    base = n_we;
    send(1'b1, 8'h01);
    for (int k = 0; k < 300 && (n_we - base) < 40; k++) begin
      @(posedge clk); #1;
    end
    check("mid_pulses", 32'(n_we - base), 32'd40);
    rst = 1'b1;
    #1;
    exp_q.delete();
    m_cur = 7'd0;
    m_en = 1'b0;
    check_zero("mid_rst");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_pulses", 32'(n_we - base), 32'd40);
    check_zero("post_rst");
    check("queue_drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
